// File: rtl/bcd_conv_sched_pkg.sv
// Shared definitions for the sequential binary-to-BCD conversion engine.
package bcd_pkg;

    // Default operand width and BCD digit count (10^DIGITS must exceed 2^WIDTH-1).
    localparam int unsigned WIDTH_DEF  = 16;
    localparam int unsigned DIGITS_DEF = 5;
    localparam int unsigned DIGIT_W    = 4;

    // Controller state encoding, kept as plain constants for legacy compatibility.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Index of a requester (0 or 1).
    typedef logic req_id_t;

endpackage

// File: rtl/bcd_conv_sched_if.sv
// Requester/result bundle between the datapath taps and the shared BCD converter.
interface bcd_conv_sched_if
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
);

    logic                        req0;
    logic                        req1;
    logic [WIDTH-1:0]            bin0;
    logic [WIDTH-1:0]            bin1;
    logic                        gnt0;
    logic                        gnt1;
    logic                        busy;
    logic                        done;
    req_id_t                     done_id;
    logic [DIGITS*DIGIT_W-1:0]   bcd;

    // Requester side: raises requests and operands, observes grants and results.
    modport master (
        output req0, req1, bin0, bin1,
        input  gnt0, gnt1, busy, done, done_id, bcd
    );

    // Converter side.
    modport slave (
        input  req0, req1, bin0, bin1,
        output gnt0, gnt1, busy, done, done_id, bcd
    );

endinterface

// File: rtl/bcd_conv_sched_dabble_step.sv
// One shift-add-3 iteration: correct every BCD digit >= 5 by +3, then shift
// the whole {digits, operand} vector left by one bit.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic [DIGITS*DIGIT_W+WIDTH-1:0] vec_i,
    output logic [DIGITS*DIGIT_W+WIDTH-1:0] vec_o
);

    localparam int unsigned VW = DIGITS*DIGIT_W + WIDTH;

    logic [VW-1:0] adj;

    // Per-digit correction (4-bit, no carry out) followed by the one-bit shift.
    always_comb begin
        adj = vec_i;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (vec_i[WIDTH + d*DIGIT_W +: DIGIT_W] >= 4'd5) begin
                adj[WIDTH + d*DIGIT_W +: DIGIT_W] = vec_i[WIDTH + d*DIGIT_W +: DIGIT_W] + 4'd3;
            end
        end
        vec_o = {adj[VW-2:0], 1'b0};
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Shared iterative binary-to-BCD converter with a two-requester round-robin
// front end. One conversion takes WIDTH shift cycles plus grant and done cycles.
module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_conv_sched_if.slave   bus
);

    localparam int unsigned BW = DIGITS*DIGIT_W;
    localparam int unsigned VW = BW + WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]     state_q, state_d;
    req_id_t        prio_q, prio_d;
    req_id_t        owner_q, owner_d;
    req_id_t        done_id_q, done_id_d;
    logic           gnt0_q, gnt0_d;
    logic           gnt1_q, gnt1_d;
    logic           done_q, done_d;
    logic [BW-1:0]  bcd_q, bcd_d;
    logic [VW-1:0]  vec_q, vec_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [VW-1:0]  step_vec;
    req_id_t        pick;

    bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_step (
        .vec_i (vec_q),
        .vec_o (step_vec)
    );

    // Arbitration, iteration control and result publication.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        done_id_d = done_id_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        // Requester 1 wins when it is alone or when both ask and it holds priority.
        pick      = bus.req1 & (~bus.req0 | prio_q);
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    vec_d   = {{BW{1'b0}}, (pick ? bus.bin1 : bus.bin0)};
                    cnt_d   = '0;
                    owner_d = pick;
                    prio_d  = ~pick;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                vec_d = step_vec;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d     = vec_q[VW-1 -: BW];
                done_id_d = owner_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            done_id_q <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            vec_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            done_id_q <= done_id_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.bcd     = bcd_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: randomized jobs against a decimal
// reference model, plus directed latency, arbitration and reset scenarios.
module tb_bcd_conv_sched;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    bcd_conv_sched_if #(.WIDTH(16), .DIGITS(5)) bus ();

    bcd_conv_sched #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: decimal digits by plain division.
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        int unsigned x;
        logic [19:0] r;
        x = v;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one request and wait (bounded) for its grant and done; -1 on timeout.
    task automatic serve(input int which, input logic [15:0] v,
                         output int glat, output int dlat, output logic gid,
                         output logic [19:0] r, output logic id);
        glat = -1; dlat = -1; gid = 1'b0; r = '0; id = 1'b0;
        if (which == 0) begin bus.req0 = 1'b1; bus.bin0 = v; end
        else            begin bus.req1 = 1'b1; bus.bin1 = v; end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.gnt0 | bus.gnt1) begin glat = i; gid = bus.gnt1; break; end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (glat > 0) begin
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (bus.done) begin dlat = i; r = bus.bcd; id = bus.done_id; break; end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus.req0 = 1'($urandom % 2);
            bus.req1 = 1'($urandom % 2);
            bus.bin0 = 16'($urandom);
            bus.bin1 = 16'($urandom);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.gnt0 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt0: got %b expected 0", bus.gnt0); end
        vectors++; if (bus.gnt1 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt1: got %b expected 0", bus.gnt1); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        vectors++; if (bus.done_id !== 1'b0) begin miscompares++; $display("FAIL reset_done_id: got %b expected 0", bus.done_id); end
        vectors++; if (bus.bcd !== 20'h0) begin miscompares++; $display("FAIL reset_bcd: got %h expected 00000", bus.bcd); end
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy: got %b expected 0", bus.busy); end
        vectors++; if ({bus.gnt0, bus.gnt1, bus.done} !== 3'b000) begin miscompares++; $display("FAIL post_reset_pulses: got %b expected 000", {bus.gnt0, bus.gnt1, bus.done}); end
    endtask

    task automatic test_single();
        int n;
        n = -1;
        @(negedge clk);
        bus.req0 = 1'b1;
        bus.bin0 = 16'd1234;
        @(negedge clk);
        vectors++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin miscompares++; $display("FAIL single_gnt: got %b expected 10", {bus.gnt0, bus.gnt1}); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_at_gnt: got %b expected 1", bus.busy); end
        bus.req0 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin n = i; break; end
            vectors++; if ({bus.busy, bus.gnt0, bus.gnt1} !== 3'b100) begin miscompares++; $display("FAIL single_busy_cycle%0d: got %b expected 100", i, {bus.busy, bus.gnt0, bus.gnt1}); end
        end
        vectors++; if (n !== 17) begin miscompares++; $display("FAIL single_latency: got %0d expected 17", n); end
        vectors++; if (bus.bcd !== ref_bcd(1234)) begin miscompares++; $display("FAIL single_bcd: got %h expected %h", bus.bcd, ref_bcd(1234)); end
        vectors++; if (bus.done_id !== 1'b0) begin miscompares++; $display("FAIL single_id: got %b expected 0", bus.done_id); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_at_done: got %b expected 0", bus.busy); end
        @(negedge clk);
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL single_done_pulse: got %b expected 0", bus.done); end
        vectors++; if (bus.bcd !== 20'h01234) begin miscompares++; $display("FAIL single_bcd_hold: got %h expected 01234", bus.bcd); end
    endtask

    task automatic test_boundary();
        int unsigned vals[4];
        int glat, dlat;
        logic gid, id;
        logic [19:0] r;
        vals = '{0, 9999, 10000, 65535};
        foreach (vals[k]) begin
            serve(1, 16'(vals[k]), glat, dlat, gid, r, id);
            vectors++; if (glat !== 1 || gid !== 1'b1) begin miscompares++; $display("FAIL bound_gnt_%0d: got lat %0d id %b expected lat 1 id 1", vals[k], glat, gid); end
            vectors++; if (dlat !== 17) begin miscompares++; $display("FAIL bound_latency_%0d: got %0d expected 17", vals[k], dlat); end
            vectors++; if (r !== ref_bcd(vals[k])) begin miscompares++; $display("FAIL bound_bcd_%0d: got %h expected %h", vals[k], r, ref_bcd(vals[k])); end
            vectors++; if (id !== 1'b1) begin miscompares++; $display("FAIL bound_id_%0d: got %b expected 1", vals[k], id); end
        end
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        @(negedge clk);
        bus.req0 = 1'b1; bus.bin0 = 16'd42;
        bus.req1 = 1'b1; bus.bin1 = 16'd907;
        @(negedge clk);
        vectors++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin miscompares++; $display("FAIL simul_first_gnt: got %b expected 10", {bus.gnt0, bus.gnt1}); end
        bus.req0 = 1'b0;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin n = i; break; end
        end
        vectors++; if (n !== 17 || bus.bcd !== 20'h00042 || bus.done_id !== 1'b0) begin miscompares++; $display("FAIL simul_first_result: got lat %0d bcd %h id %b expected lat 17 bcd 00042 id 0", n, bus.bcd, bus.done_id); end
        @(negedge clk);
        vectors++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin miscompares++; $display("FAIL simul_second_gnt: got %b expected 01", {bus.gnt0, bus.gnt1}); end
        bus.req1 = 1'b0;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin n = i; break; end
        end
        vectors++; if (n !== 17 || bus.bcd !== 20'h00907 || bus.done_id !== 1'b1) begin miscompares++; $display("FAIL simul_second_result: got lat %0d bcd %h id %b expected lat 17 bcd 00907 id 1", n, bus.bcd, bus.done_id); end
    endtask

    task automatic test_fairness();
        int jobs, dones, last_gnt_cyc;
        logic exp_next;
        logic exp_id;
        int unsigned exp_val;
        jobs = 0; dones = 0; last_gnt_cyc = 0; exp_next = 1'b0; exp_id = 1'b0; exp_val = 0;
        do_reset();
        @(negedge clk);
        bus.req0 = 1'b1; bus.bin0 = 16'($urandom);
        bus.req1 = 1'b1; bus.bin1 = 16'($urandom);
        for (int cyc = 1; cyc <= 6*18 + 20; cyc++) begin
            @(negedge clk);
            if (bus.gnt0 | bus.gnt1) begin
                jobs++;
                vectors++; if ({bus.gnt0, bus.gnt1} !== (exp_next ? 2'b01 : 2'b10)) begin miscompares++; $display("FAIL fair_order_job%0d: got %b expected %b", jobs, {bus.gnt0, bus.gnt1}, (exp_next ? 2'b01 : 2'b10)); end
                if (jobs > 1) begin
                    vectors++; if (cyc - last_gnt_cyc !== 18) begin miscompares++; $display("FAIL fair_spacing_job%0d: got %0d expected 18", jobs, cyc - last_gnt_cyc); end
                end
                last_gnt_cyc = cyc;
                exp_id  = exp_next;
                exp_val = exp_next ? int'(bus.bin1) : int'(bus.bin0);
                exp_next = ~exp_next;
                // Operand of the granted requester changes while its request stays high.
                if (exp_id == 1'b0) bus.bin0 = 16'($urandom);
                else                bus.bin1 = 16'($urandom);
            end
            if (bus.done) begin
                dones++;
                vectors++; if (bus.bcd !== ref_bcd(exp_val) || bus.done_id !== exp_id) begin miscompares++; $display("FAIL fair_result_job%0d: got bcd %h id %b expected bcd %h id %b", dones, bus.bcd, bus.done_id, ref_bcd(exp_val), exp_id); end
                if (dones == 6) break;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        vectors++; if (jobs !== 6 || dones !== 6) begin miscompares++; $display("FAIL fair_job_count: got grants %0d dones %0d expected 6 6", jobs, dones); end
    endtask

    task automatic test_reset_midop();
        int glat, dlat;
        logic gid, id;
        logic [19:0] r;
        logic seen_done;
        seen_done = 1'b0;
        @(negedge clk);
        bus.req0 = 1'b1;
        bus.bin0 = 16'($urandom);
        @(negedge clk);
        vectors++; if (bus.gnt0 !== 1'b1) begin miscompares++; $display("FAIL midop_gnt: got %b expected 1", bus.gnt0); end
        bus.req0 = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.busy !== 1'b0 || bus.bcd !== 20'h0) begin miscompares++; $display("FAIL midop_abort: got busy %b bcd %h expected busy 0 bcd 00000", bus.busy, bus.bcd); end
        repeat (3) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL midop_no_done: got %b expected 0", seen_done); end
        vectors++; if (bus.bcd !== 20'h0) begin miscompares++; $display("FAIL midop_bcd_cleared: got %h expected 00000", bus.bcd); end
        serve(0, 16'd5555, glat, dlat, gid, r, id);
        vectors++; if (dlat !== 17 || r !== 20'h05555 || id !== 1'b0) begin miscompares++; $display("FAIL midop_recover: got lat %0d bcd %h id %b expected lat 17 bcd 05555 id 0", dlat, r, id); end
    endtask

    task automatic test_random();
        int glat, dlat, which;
        logic gid, id;
        logic [19:0] r;
        logic [15:0] v;
        for (int j = 0; j < 16; j++) begin
            which = int'($urandom % 2);
            v     = 16'($urandom);
            repeat ($urandom % 4) @(negedge clk);
            serve(which, v, glat, dlat, gid, r, id);
            vectors++; if (glat !== 1 || gid !== 1'(which)) begin miscompares++; $display("FAIL rand_gnt_job%0d: got lat %0d id %b expected lat 1 id %0d", j, glat, gid, which); end
            vectors++; if (dlat !== 17 || r !== ref_bcd(int'(v)) || id !== 1'(which)) begin miscompares++; $display("FAIL rand_result_job%0d: got lat %0d bcd %h id %b expected lat 17 bcd %h id %0d", j, dlat, r, id, ref_bcd(int'(v)), which); end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.bin0 = '0;
        bus.bin1 = '0;
        test_reset();
        test_single();
        test_boundary();
        test_simultaneous();
        test_fairness();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
